hoop_shot_detector: RTL and testbench

Front-end stage of the hoop game: conditions the three raw hoop break-beam switches (top, mid, bottom), recognises a made basket as an ordered top→mid→bottom traversal within a time window, and emits one single-cycle `score_pulse` per basket to the downstream score counter. It also flags out-of-order or timed-out traversals and enforces a post-score lockout so a single ball can never score twice.

---
 rtl/hoop_shot_detector.sv | 191 +++++++++++++++++++
 tb/tb_hoop_shot_detector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hoop_shot_detector.sv
// hoop_shot_detector
//
// Front end of the hoop game. Conditions the three break-beam switches and
// recognises a made basket as an ordered top -> mid -> bottom traversal
// inside a time window. Each basket gives one single-cycle score_pulse. An
// abandoned traversal (out of order or too slow) gives one shot_fault pulse.
// After a score, all events are ignored for a lockout period so one ball can
// never score twice.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low
//   sw_top/mid/bot  raw asynchronous beam levels, high = beam broken
//   game_active  high while the countdown runs; low suppresses scoring
//   score_pulse  one-cycle pulse per made basket (registered)
//   shot_fault   one-cycle pulse after an abandoned traversal (registered)
//   busy         high whenever the FSM is not IDLE (registered)
//   state        FSM state for debug: IDLE=0 TOP=1 MID=2 SCORE=3 LOCKOUT=4
module hoop_shot_detector #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SEQ_TIMEOUT     = 25000000,
    parameter int LOCKOUT_CYCLES  = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sw_top,
    input  logic       sw_mid,
    input  logic       sw_bot,
    input  logic       game_active,
    output logic       score_pulse,
    output logic       shot_fault,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TOP     = 3'd1,
        MID     = 3'd2,
        SCORE   = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]        TO_LAST = 32'(SEQ_TIMEOUT - 1);
    localparam logic [31:0]        LO_LAST = 32'(LOCKOUT_CYCLES - 1);

    // Shared timer saturates rather than wrapping so a stuck state can never
    // alias back onto a timeout compare value.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Bit order for all per-switch vectors: [0]=top, [1]=mid, [2]=bot.
    logic [2:0]       raw;
    logic [2:0]       sync_p0;
    logic [2:0]       sync_p1;
    logic [2:0]       filt;
    logic [2:0]       filt_d;
    logic [CNT_W-1:0] db_cnt [3];
    logic [2:0]       ev;
    logic             ev_top;
    logic             ev_mid;
    logic             ev_bot;

    logic [31:0]      timer;
    logic             timer_clr;
    logic             fault;
    state_t           cur;
    state_t           nxt;

    assign raw = {sw_bot, sw_mid, sw_top};

    // ---- stage p0/p1: two-flop synchroniser, debounce filter, edge history
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            filt    <= '0;
            filt_d  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            filt_d  <= filt;
            for (int i = 0; i < 3; i++) begin
                // A one-bit level that changes while it differs from the
                // filtered level lands back on it, so the equality clear also
                // covers the "synchronised level changed" restart.
                if (sync_p1[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edges only; both operands are flops, so events are glitch-free.
    assign ev     = filt & ~filt_d;
    assign ev_top = ev[0];
    assign ev_mid = ev[1];
    assign ev_bot = ev[2];

    // ---- stage p2: traversal FSM
    always_comb begin
        nxt       = cur;
        fault     = 1'b0;
        timer_clr = 1'b0;
        if (!game_active) begin
            // Abort silently: no fault and no score while the game is off.
            nxt = IDLE;
        end else begin
            case (cur)
                IDLE: begin
                    if (ev_top) nxt = TOP;
                end
                TOP: begin
                    if (ev_mid) begin
                        nxt = MID;
                    end else if (ev_bot) begin
                        nxt   = IDLE;
                        fault = 1'b1;
                    end else if (ev_top) begin
                        // Re-entry into TOP restarts the window.
                        timer_clr = 1'b1;
                    end else if (timer == TO_LAST) begin
                        nxt   = IDLE;
                        fault = 1'b1;
                    end
                end
                MID: begin
                    if (ev_bot) begin
                        nxt = SCORE;
                    end else if (ev_top) begin
                        nxt   = IDLE;
                        fault = 1'b1;
                    end else if (timer == TO_LAST) begin
                        nxt   = IDLE;
                        fault = 1'b1;
                    end
                end
                SCORE: begin
                    nxt = LOCKOUT;
                end
                LOCKOUT: begin
                    if (timer == LO_LAST) nxt = IDLE;
                end
                default: begin
                    nxt = IDLE;
                end
            endcase
        end
        if (nxt != cur) timer_clr = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else begin
            timer <= sat_inc(timer);
        end
    end

    // Outputs are registered from the next-state decode. SCORE is only ever
    // entered with game_active high, so the pulse is already qualified.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cur         <= IDLE;
            score_pulse <= 1'b0;
            shot_fault  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cur         <= nxt;
            score_pulse <= (nxt == SCORE);
            shot_fault  <= fault;
            busy        <= (nxt != IDLE);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_hoop_shot_detector.sv
module tb_hoop_shot_detector;

    localparam int DB = 4;
    localparam int TO = 20;
    localparam int LO = 8;
    // Cycles from driving a raw rise (just after edge N) to the state change
    // it causes: sync after N+2, filtered after N+2+DB, event cycle, edge.
    localparam int LAT = DB + 3;

    localparam int K_STATE = 0;
    localparam int K_SCORE = 1;
    localparam int K_FAULT = 2;

    logic       clock;
    logic       reset;
    logic [2:0] sw;          // [0]=top [1]=mid [2]=bot
    logic       game_active;
    logic       score_pulse;
    logic       shot_fault;
    logic       busy;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n;
    logic       mon_en = 1'b0;
    logic [2:0] prev_state = 3'd0;

    typedef struct {
        int kind;
        int val;
        int at;
    } exp_t;
    exp_t sb[$];

    hoop_shot_detector #(
        .DEBOUNCE_CYCLES(DB),
        .SEQ_TIMEOUT    (TO),
        .LOCKOUT_CYCLES (LO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sw_top     (sw[0]),
        .sw_mid     (sw[1]),
        .sw_bot     (sw[2]),
        .game_active(game_active),
        .score_pulse(score_pulse),
        .shot_fault (shot_fault),
        .busy       (busy),
        .state      (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    task automatic push(input int kind, input int val, input int at);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_val", val, e.val);
            chk("event_cycle", cyc, e.at);
        end
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (state !== prev_state) begin
                observe(K_STATE, int'(state));
                chk("busy_vs_state", int'(busy), int'(state != 3'd0));
            end
            prev_state = state;
            if (score_pulse !== 1'b0) observe(K_SCORE, 1);
            if (shot_fault !== 1'b0) observe(K_FAULT, 1);
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input int idx, input int start, input int hold);
        go_to(start);
        sw[idx] = 1'b1;
        go_to(start + hold);
        sw[idx] = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_score"}, int'(score_pulse), 0);
        chk({tag, "_fault"}, int'(shot_fault), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        sw          = 3'b000;
        game_active = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        reset  = 1'b1;
        mon_en = 1'b1;

        // Ordered shot
        n = cyc + 2;
        push(K_STATE, 1, n + LAT);
        push(K_STATE, 2, n + 13 + LAT);
        push(K_STATE, 3, n + 26 + LAT);
        push(K_SCORE, 1, n + 26 + LAT);
        push(K_STATE, 4, n + 26 + LAT + 1);
        push(K_STATE, 0, n + 26 + LAT + 1 + LO);
        press(0, n, 10);
        press(1, n + 13, 10);
        press(2, n + 26, 10);
        go_to(n + 60);
        chk("ordered_drained", sb.size(), 0);

        // Bounce rejection: 2-cycle glitches never survive the filter
        n = cyc + 1;
        for (int i = 0; i < 15; i++) begin
            go_to(n + 2 * i);
            sw[0] = (i % 2 == 0);
        end
        go_to(n + 30);
        sw[0] = 1'b0;
        go_to(n + 45);
        chk("bounce_state", int'(state), 0);
        chk("bounce_drained", sb.size(), 0);

        // Out of order: top then bot
        n = cyc + 1;
        push(K_STATE, 1, n + LAT);
        push(K_STATE, 0, n + 13 + LAT);
        push(K_FAULT, 1, n + 13 + LAT);
        press(0, n, 10);
        press(2, n + 13, 10);
        go_to(n + 40);
        chk("order_drained", sb.size(), 0);

        // Timeout: TOP abandoned exactly TO cycles after entry
        n = cyc + 1;
        push(K_STATE, 1, n + LAT);
        push(K_STATE, 0, n + LAT + TO);
        push(K_FAULT, 1, n + LAT + TO);
        press(0, n, 10);
        go_to(n + 50);
        chk("timeout_drained", sb.size(), 0);

        // Lockout: extra bot event inside LOCKOUT is ignored, then a new
        // traversal scores again
        n = cyc + 1;
        push(K_STATE, 1, n + LAT);
        push(K_STATE, 2, n + 13 + LAT);
        push(K_STATE, 3, n + 26 + LAT);
        push(K_SCORE, 1, n + 26 + LAT);
        push(K_STATE, 4, n + 34);
        push(K_STATE, 0, n + 34 + LO);
        push(K_STATE, 1, n + 50 + LAT);
        push(K_STATE, 2, n + 63 + LAT);
        push(K_STATE, 3, n + 76 + LAT);
        push(K_SCORE, 1, n + 76 + LAT);
        push(K_STATE, 4, n + 84);
        push(K_STATE, 0, n + 84 + LO);
        press(0, n, 10);
        press(1, n + 13, 10);
        press(2, n + 26, 4);
        press(2, n + 34, 4);     // event lands at edge n+41, inside LOCKOUT
        press(0, n + 50, 10);
        press(1, n + 63, 10);
        press(2, n + 76, 10);
        go_to(n + 110);
        chk("lockout_drained", sb.size(), 0);

        // game_active drop in MID, then top ignored while inactive
        n = cyc + 1;
        push(K_STATE, 1, n + LAT);
        push(K_STATE, 2, n + 13 + LAT);
        push(K_STATE, 0, n + 23);
        press(0, n, 10);
        go_to(n + 13);
        sw[1] = 1'b1;
        go_to(n + 22);
        game_active = 1'b0;
        go_to(n + 23);
        sw[1] = 1'b0;
        press(0, n + 25, 10);
        go_to(n + 40);
        chk("inactive_state", int'(state), 0);
        game_active = 1'b1;
        go_to(n + 50);
        chk("inactive_drained", sb.size(), 0);

        // One-cycle reset while in LOCKOUT
        n = cyc + 1;
        push(K_STATE, 1, n + LAT);
        push(K_STATE, 2, n + 13 + LAT);
        push(K_STATE, 3, n + 26 + LAT);
        push(K_SCORE, 1, n + 26 + LAT);
        push(K_STATE, 4, n + 34);
        push(K_STATE, 0, n + 37);
        press(0, n, 10);
        press(1, n + 13, 10);
        press(2, n + 26, 10);
        go_to(n + 36);
        chk("pre_reset_state", int'(state), 4);
        reset = 1'b0;
        go_to(n + 37);
        reset = 1'b1;
        check_idle_outputs("lockout_reset");
        go_to(n + 60);
        chk("reset_state_after", int'(state), 0);
        chk("final_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
